// File: rtl/axi_sram_responder_if.sv
// AXI3 32-bit bus bundle between the CPU-side master and the SRAM responder.
// Lock/cache/prot and wid are carried for completeness; the responder ignores them.
interface axi_sram_responder_if;
   logic [3:0]  arid;
   logic [31:0] araddr;
   logic [3:0]  arlen;
   logic [2:0]  arsize;
   logic [1:0]  arburst;
   logic [1:0]  arlock;
   logic [3:0]  arcache;
   logic [2:0]  arprot;
   logic        arvalid;
   logic        arready;

   logic [3:0]  rid;
   logic [31:0] rdata;
   logic [1:0]  rresp;
   logic        rlast;
   logic        rvalid;
   logic        rready;

   logic [3:0]  awid;
   logic [31:0] awaddr;
   logic [3:0]  awlen;
   logic [2:0]  awsize;
   logic [1:0]  awburst;
   logic [1:0]  awlock;
   logic [3:0]  awcache;
   logic [2:0]  awprot;
   logic        awvalid;
   logic        awready;

   logic [3:0]  wid;
   logic [31:0] wdata;
   logic [3:0]  wstrb;
   logic        wlast;
   logic        wvalid;
   logic        wready;

   logic [3:0]  bid;
   logic [1:0]  bresp;
   logic        bvalid;
   logic        bready;

   modport slave (
      input  arid, araddr, arlen, arsize, arburst, arlock, arcache, arprot, arvalid,
      output arready,
      output rid, rdata, rresp, rlast, rvalid,
      input  rready,
      input  awid, awaddr, awlen, awsize, awburst, awlock, awcache, awprot, awvalid,
      output awready,
      input  wid, wdata, wstrb, wlast, wvalid,
      output wready,
      output bid, bresp, bvalid,
      input  bready
   );

   modport master (
      output arid, araddr, arlen, arsize, arburst, arlock, arcache, arprot, arvalid,
      input  arready,
      input  rid, rdata, rresp, rlast, rvalid,
      output rready,
      output awid, awaddr, awlen, awsize, awburst, awlock, awcache, awprot, awvalid,
      input  awready,
      output wid, wdata, wstrb, wlast, wvalid,
      input  wready,
      input  bid, bresp, bvalid,
      output bready
   );
endinterface

// File: rtl/axi_sram_responder.sv
// AXI3 slave backed by a word-addressed on-chip SRAM; independent read and write
// FSMs with one transaction outstanding each, INCR/FIXED bursts, programmable read latency.
module axi_sram_responder #(
   parameter int ADDR_WIDTH = 12,
   parameter int RD_DELAY   = 2
) (
   input  logic                 aclk,
   input  logic                 aresetn,
   axi_sram_responder_if.slave  axi
);
   localparam int DEPTH = 1 << ADDR_WIDTH;
   localparam logic [1:0] BURST_FIXED = 2'b00;
   localparam logic [1:0] BURST_INCR  = 2'b01;
   localparam logic [1:0] RESP_OKAY   = 2'b00;
   localparam logic [1:0] RESP_SLVERR = 2'b10;

   typedef enum logic [1:0] {R_IDLE, R_WAIT, R_DATA} r_state_t;
   typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} w_state_t;

   function automatic logic burst_bad(input logic [1:0] burst, input logic [2:0] size);
      return !((burst == BURST_FIXED) || (burst == BURST_INCR)) || (size > 3'd2);
   endfunction

   function automatic logic [31:0] step_addr(input logic [31:0] addr, input logic [1:0] burst,
                                             input logic [2:0] size);
      return (burst == BURST_INCR) ? addr + (32'd1 << size) : addr;
   endfunction

   // read channel state
   r_state_t    r_state_reg;
   logic [31:0] r_addr_reg;
   logic [3:0]  r_len_reg;
   logic [3:0]  r_beat_reg;
   logic [2:0]  r_size_reg;
   logic [1:0]  r_burst_reg;
   logic        r_err_reg;
   logic [3:0]  r_delay_reg;
   logic        arready_reg;
   logic        rvalid_reg;
   logic        rlast_reg;
   logic [31:0] rdata_reg;
   logic [1:0]  rresp_reg;
   logic [3:0]  rid_reg;

   // write channel state
   w_state_t    w_state_reg;
   logic [31:0] w_addr_reg;
   logic [3:0]  w_len_reg;
   logic [3:0]  w_beat_reg;
   logic [2:0]  w_size_reg;
   logic [1:0]  w_burst_reg;
   logic        w_err_reg;
   logic        w_last_err_reg;
   logic        awready_reg;
   logic        wready_reg;
   logic        bvalid_reg;
   logic [1:0]  bresp_reg;
   logic [3:0]  bid_reg;

   logic [31:0]           r_next_addr;
   logic [31:0]           r_load_addr;
   logic [ADDR_WIDTH-1:0] rd_idx;
   logic [ADDR_WIDTH-1:0] w_idx;
   logic [31:0]           rd_word;
   logic                  w_fire;
   logic                  w_final;
   logic                  w_last_bad;
   logic                  mem_we;

   // The first beat reads the latched address; later beats read the stepped one.
   assign r_next_addr = step_addr(r_addr_reg, r_burst_reg, r_size_reg);
   assign r_load_addr = (r_state_reg == R_WAIT) ? r_addr_reg : r_next_addr;
   assign rd_idx      = r_load_addr[ADDR_WIDTH+1:2];
   assign w_idx       = w_addr_reg[ADDR_WIDTH+1:2];

   assign w_fire     = (w_state_reg == W_DATA) && wready_reg && axi.wvalid;
   assign w_final    = (w_beat_reg == w_len_reg);
   assign w_last_bad = (axi.wlast != w_final);
   assign mem_we     = w_fire && !w_err_reg;

   // One byte-wide array per lane so strobed writes map onto plain RAM write ports.
   genvar gi;
   generate
      for (gi = 0; gi < 4; gi++) begin : g_lane
         logic [7:0] lane_mem [DEPTH];
         always_ff @(posedge aclk) begin
            if (mem_we && axi.wstrb[gi]) begin
               lane_mem[w_idx] <= axi.wdata[8*gi +: 8];
            end
         end
         assign rd_word[8*gi +: 8] = lane_mem[rd_idx];
      end
   endgenerate

   always_ff @(posedge aclk or negedge aresetn) begin
      if (!aresetn) begin
         r_state_reg <= R_IDLE;
         r_addr_reg  <= '0;
         r_len_reg   <= '0;
         r_beat_reg  <= '0;
         r_size_reg  <= '0;
         r_burst_reg <= '0;
         r_err_reg   <= 1'b0;
         r_delay_reg <= '0;
         arready_reg <= 1'b0;
         rvalid_reg  <= 1'b0;
         rlast_reg   <= 1'b0;
         rdata_reg   <= '0;
         rresp_reg   <= RESP_OKAY;
         rid_reg     <= '0;
      end else begin
         case (r_state_reg)
            R_IDLE: begin
               if (arready_reg && axi.arvalid) begin
                  arready_reg <= 1'b0;
                  rid_reg     <= axi.arid;
                  r_addr_reg  <= axi.araddr;
                  r_len_reg   <= axi.arlen;
                  r_size_reg  <= axi.arsize;
                  r_burst_reg <= axi.arburst;
                  r_err_reg   <= burst_bad(axi.arburst, axi.arsize);
                  r_delay_reg <= 4'(RD_DELAY);
                  r_beat_reg  <= '0;
                  r_state_reg <= R_WAIT;
               end else begin
                  arready_reg <= 1'b1;
               end
            end
            R_WAIT: begin
               if (r_delay_reg == 4'd0) begin
                  rvalid_reg  <= 1'b1;
                  rdata_reg   <= r_err_reg ? 32'h0 : rd_word;
                  rresp_reg   <= r_err_reg ? RESP_SLVERR : RESP_OKAY;
                  rlast_reg   <= (r_len_reg == 4'd0);
                  r_state_reg <= R_DATA;
               end else begin
                  r_delay_reg <= r_delay_reg - 4'd1;
               end
            end
            R_DATA: begin
               if (axi.rready) begin
                  if (rlast_reg) begin
                     rvalid_reg  <= 1'b0;
                     rlast_reg   <= 1'b0;
                     arready_reg <= 1'b1;
                     r_state_reg <= R_IDLE;
                  end else begin
                     r_addr_reg <= r_next_addr;
                     r_beat_reg <= r_beat_reg + 4'd1;
                     rdata_reg  <= r_err_reg ? 32'h0 : rd_word;
                     rlast_reg  <= ((r_beat_reg + 4'd1) == r_len_reg);
                  end
               end
            end
            default: r_state_reg <= R_IDLE;
         endcase
      end
   end

   always_ff @(posedge aclk or negedge aresetn) begin
      if (!aresetn) begin
         w_state_reg    <= W_IDLE;
         w_addr_reg     <= '0;
         w_len_reg      <= '0;
         w_beat_reg     <= '0;
         w_size_reg     <= '0;
         w_burst_reg    <= '0;
         w_err_reg      <= 1'b0;
         w_last_err_reg <= 1'b0;
         awready_reg    <= 1'b0;
         wready_reg     <= 1'b0;
         bvalid_reg     <= 1'b0;
         bresp_reg      <= RESP_OKAY;
         bid_reg        <= '0;
      end else begin
         case (w_state_reg)
            W_IDLE: begin
               if (awready_reg && axi.awvalid) begin
                  awready_reg    <= 1'b0;
                  wready_reg     <= 1'b1;
                  bid_reg        <= axi.awid;
                  w_addr_reg     <= axi.awaddr;
                  w_len_reg      <= axi.awlen;
                  w_size_reg     <= axi.awsize;
                  w_burst_reg    <= axi.awburst;
                  w_err_reg      <= burst_bad(axi.awburst, axi.awsize);
                  w_last_err_reg <= 1'b0;
                  w_beat_reg     <= '0;
                  w_state_reg    <= W_DATA;
               end else begin
                  awready_reg <= 1'b1;
               end
            end
            W_DATA: begin
               if (w_fire) begin
                  w_addr_reg <= step_addr(w_addr_reg, w_burst_reg, w_size_reg);
                  w_beat_reg <= w_beat_reg + 4'd1;
                  if (w_last_bad) begin
                     w_last_err_reg <= 1'b1;
                  end
                  // Burst length comes from awlen alone; a misplaced wlast only flags the response.
                  if (w_final) begin
                     wready_reg  <= 1'b0;
                     bvalid_reg  <= 1'b1;
                     bresp_reg   <= (w_err_reg || w_last_err_reg || w_last_bad) ? RESP_SLVERR : RESP_OKAY;
                     w_state_reg <= W_RESP;
                  end
               end
            end
            W_RESP: begin
               if (axi.bready) begin
                  bvalid_reg  <= 1'b0;
                  awready_reg <= 1'b1;
                  w_state_reg <= W_IDLE;
               end
            end
            default: w_state_reg <= W_IDLE;
         endcase
      end
   end

   assign axi.arready = arready_reg;
   assign axi.rvalid  = rvalid_reg;
   assign axi.rlast   = rlast_reg;
   assign axi.rdata   = rdata_reg;
   assign axi.rresp   = rresp_reg;
   assign axi.rid     = rid_reg;
   assign axi.awready = awready_reg;
   assign axi.wready  = wready_reg;
   assign axi.bvalid  = bvalid_reg;
   assign axi.bresp   = bresp_reg;
   assign axi.bid     = bid_reg;

   logic unused_ok;
   assign unused_ok = ^{axi.arlock, axi.arcache, axi.arprot, axi.awlock, axi.awcache, axi.awprot,
                        axi.wid, r_load_addr[31:ADDR_WIDTH+2], r_load_addr[1:0],
                        w_addr_reg[31:ADDR_WIDTH+2], w_addr_reg[1:0]};
endmodule

// File: tb/tb_axi_sram_responder.sv
// Directed bench for axi_sram_responder: a word model plus read/write response queues
// supply the expected values that every R and B beat is checked against.
module tb_axi_sram_responder;
   localparam int ADDR_WIDTH = 12;
   localparam int RD_DELAY   = 2;

   logic aclk    = 1'b0;
   logic aresetn = 1'b0;
   always #5 aclk = ~aclk;

   axi_sram_responder_if axi ();

   axi_sram_responder #(.ADDR_WIDTH(ADDR_WIDTH), .RD_DELAY(RD_DELAY)) dut (
      .aclk    (aclk),
      .aresetn (aresetn),
      .axi     (axi)
   );

   typedef struct packed {
      logic [31:0] data;
      logic [1:0]  resp;
      logic        last;
      logic [3:0]  id;
   } rexp_t;

   typedef struct packed {
      logic [1:0] resp;
      logic [3:0] id;
   } bexp_t;

   int          n_cmp = 0;
   int          n_mis = 0;
   int          cyc   = 0;
   logic [31:0] model [4096];
   rexp_t       rq [$];
   bexp_t       bq [$];
   logic [31:0] wbuf [16];
   logic [3:0]  sbuf [16];

   task automatic tick();
      @(posedge aclk);
      #1;
      cyc++;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_mis++;
         $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic fail_bound(input string tag);
      n_cmp++;
      n_mis++;
      $display("FAIL %s: observed=no handshake expected=handshake within bound", tag);
   endtask

   function automatic logic is_bad(input logic [1:0] burst, input logic [2:0] size);
      return !((burst == 2'b00) || (burst == 2'b01)) || (size > 3'd2);
   endfunction

   // early_last < 0: wlast on the final beat only; otherwise wlast only on that beat index.
   task automatic do_write(input logic [3:0] id, input logic [31:0] addr, input logic [3:0] len,
                           input logic [2:0] size, input logic [1:0] burst, input int early_last);
      logic        bad;
      logic        hs;
      logic [31:0] a;
      logic [1:0]  ob_resp;
      logic [3:0]  ob_id;
      bexp_t       e;
      bad    = is_bad(burst, size);
      e.id   = id;
      e.resp = (bad || early_last >= 0) ? 2'b10 : 2'b00;
      bq.push_back(e);
      a = addr;
      for (int b = 0; b <= int'(len); b++) begin
         if (!bad) begin
            for (int g = 0; g < 4; g++) begin
               if (sbuf[b][g]) model[a[13:2]][8*g +: 8] = wbuf[b][8*g +: 8];
            end
         end
         if (burst == 2'b01) a = a + (32'd1 << size);
      end

      axi.awid = id; axi.awaddr = addr; axi.awlen = len; axi.awsize = size;
      axi.awburst = burst; axi.awvalid = 1'b1;
      hs = 1'b0;
      for (int k = 0; k < 50 && !hs; k++) begin
         hs = axi.awready;
         tick();
      end
      axi.awvalid = 1'b0;
      if (!hs) begin
         fail_bound("aw_handshake");
         return;
      end

      for (int b = 0; b <= int'(len); b++) begin
         axi.wdata  = wbuf[b];
         axi.wstrb  = sbuf[b];
         axi.wlast  = (early_last < 0) ? (b == int'(len)) : (b == early_last);
         axi.wvalid = 1'b1;
         hs = 1'b0;
         for (int k = 0; k < 50 && !hs; k++) begin
            hs = axi.wready;
            tick();
         end
         if (!hs) begin
            axi.wvalid = 1'b0;
            fail_bound("w_handshake");
            return;
         end
      end
      axi.wvalid = 1'b0;
      axi.wlast  = 1'b0;
      chk("bvalid_after_last_w", axi.bvalid, 1);

      axi.bready = 1'b1;
      hs = 1'b0;
      ob_resp = '0;
      ob_id = '0;
      for (int k = 0; k < 50 && !hs; k++) begin
         hs = axi.bvalid;
         ob_resp = axi.bresp;
         ob_id = axi.bid;
         tick();
      end
      axi.bready = 1'b0;
      if (!hs) begin
         fail_bound("b_handshake");
         return;
      end
      e = bq.pop_front();
      chk("bresp", ob_resp, e.resp);
      chk("bid", ob_id, e.id);
      chk("awready_after_b", axi.awready, 1);
      $display("write id=%0d addr=%h len=%0d burst=%0d -> bresp=%0d", id, addr, len, burst, ob_resp);
   endtask

   // abort_after >= 0: return once that many beats were taken and the next beat is valid.
   task automatic do_read(input logic [3:0] id, input logic [31:0] addr, input logic [3:0] len,
                          input logic [2:0] size, input logic [1:0] burst, input bit toggle,
                          input int abort_after);
      logic        bad, hs, done, stalled, prev_last;
      logic [31:0] a, prev_data;
      int          lat, got, guard;
      rexp_t       e, o;
      bad = is_bad(burst, size);
      a = addr;
      rq.delete();
      for (int b = 0; b <= int'(len); b++) begin
         e.data = bad ? 32'h0 : model[a[13:2]];
         e.resp = bad ? 2'b10 : 2'b00;
         e.last = (b == int'(len));
         e.id   = id;
         rq.push_back(e);
         if (burst == 2'b01) a = a + (32'd1 << size);
      end

      axi.arid = id; axi.araddr = addr; axi.arlen = len; axi.arsize = size;
      axi.arburst = burst; axi.arvalid = 1'b1;
      hs = 1'b0;
      for (int k = 0; k < 50 && !hs; k++) begin
         hs = axi.arready;
         tick();
      end
      axi.arvalid = 1'b0;
      if (!hs) begin
         fail_bound("ar_handshake");
         return;
      end
      chk("arready_low_after_ar", axi.arready, 0);

      lat = 0;
      while (!axi.rvalid && lat < 60) begin
         tick();
         lat++;
      end
      chk("r_first_latency", lat, RD_DELAY + 1);

      got = 0; done = 0; stalled = 0; guard = 0;
      prev_data = '0; prev_last = 1'b0;
      while (!done && guard < 200) begin
         if (abort_after >= 0 && got == abort_after) return;
         axi.rready = toggle ? cyc[0] : 1'b1;
         if (stalled) begin
            chk("r_hold_valid", axi.rvalid, 1);
            chk("r_hold_data", axi.rdata, prev_data);
            chk("r_hold_last", axi.rlast, prev_last);
         end
         o.data = axi.rdata; o.resp = axi.rresp; o.last = axi.rlast; o.id = axi.rid;
         hs        = axi.rvalid && axi.rready;
         stalled   = axi.rvalid && !axi.rready;
         prev_data = axi.rdata;
         prev_last = axi.rlast;
         tick();
         guard++;
         if (hs) begin
            got++;
            if (rq.size() == 0) begin
               fail_bound("r_unexpected_beat");
               done = 1'b1;
            end else begin
               e = rq.pop_front();
               chk("rdata", o.data, e.data);
               chk("rresp", o.resp, e.resp);
               chk("rlast", o.last, e.last);
               chk("rid", o.id, e.id);
               if (o.last) done = 1'b1;
            end
         end
      end
      axi.rready = 1'b0;
      if (!done) begin
         fail_bound("r_last_beat");
         return;
      end
      chk("r_beats_left", rq.size(), 0);
      chk("arready_after_last_r", axi.arready, 1);
      $display("read id=%0d addr=%h len=%0d burst=%0d beats=%0d", id, addr, len, burst, got);
   endtask

   initial begin
      axi.arid = '0; axi.araddr = '0; axi.arlen = '0; axi.arsize = '0; axi.arburst = '0;
      axi.arlock = '0; axi.arcache = '0; axi.arprot = '0; axi.arvalid = 1'b0; axi.rready = 1'b0;
      axi.awid = '0; axi.awaddr = '0; axi.awlen = '0; axi.awsize = '0; axi.awburst = '0;
      axi.awlock = '0; axi.awcache = '0; axi.awprot = '0; axi.awvalid = 1'b0;
      axi.wid = '0; axi.wdata = '0; axi.wstrb = '0; axi.wlast = 1'b0; axi.wvalid = 1'b0;
      axi.bready = 1'b0;

      repeat (3) @(posedge aclk);
      #1;
      chk("rst_arready", axi.arready, 0);
      chk("rst_awready", axi.awready, 0);
      chk("rst_rvalid", axi.rvalid, 0);
      chk("rst_rlast", axi.rlast, 0);
      chk("rst_wready", axi.wready, 0);
      chk("rst_bvalid", axi.bvalid, 0);
      chk("rst_rdata", axi.rdata, 0);
      chk("rst_rresp", axi.rresp, 0);
      chk("rst_bresp", axi.bresp, 0);
      chk("rst_rid", axi.rid, 0);
      chk("rst_bid", axi.bid, 0);
      @(negedge aclk);
      aresetn = 1'b1;
      #1;
      chk("arready_before_first_edge", axi.arready, 0);
      tick();
      chk("arready_first_edge", axi.arready, 1);
      chk("awready_first_edge", axi.awready, 1);

      // single beat write then read back
      wbuf[0] = 32'hDEADBEEF; sbuf[0] = 4'hF;
      do_write(4'd3, 32'h40, 4'd0, 3'd2, 2'b01, -1);
      do_read(4'd5, 32'h40, 4'd0, 3'd2, 2'b01, 1'b0, -1);

      // 16-beat INCR, read back with rready toggling
      for (int i = 0; i < 16; i++) begin
         wbuf[i] = i;
         sbuf[i] = 4'hF;
      end
      do_write(4'd1, 32'h100, 4'd15, 3'd2, 2'b01, -1);
      do_read(4'd2, 32'h100, 4'd15, 3'd2, 2'b01, 1'b1, -1);

      // FIXED burst lands every beat on one word
      for (int i = 0; i < 4; i++) wbuf[i] = i + 1;
      do_write(4'd4, 32'h200, 4'd3, 3'd2, 2'b00, -1);
      do_read(4'd6, 32'h200, 4'd0, 3'd2, 2'b01, 1'b0, -1);

      // byte strobes
      wbuf[0] = 32'h11223344; sbuf[0] = 4'hF;
      do_write(4'd7, 32'h300, 4'd0, 3'd2, 2'b01, -1);
      wbuf[0] = 32'h0000AA00; sbuf[0] = 4'h2;
      do_write(4'd7, 32'h300, 4'd0, 3'd2, 2'b01, -1);
      do_read(4'd7, 32'h300, 4'd0, 3'd2, 2'b01, 1'b0, -1);

      // WRAP read and write answer SLVERR; the write must not touch memory
      do_read(4'd8, 32'h100, 4'd3, 3'd2, 2'b10, 1'b0, -1);
      wbuf[0] = 32'hFFFFFFFF; wbuf[1] = 32'hFFFFFFFF; sbuf[0] = 4'hF; sbuf[1] = 4'hF;
      do_write(4'd9, 32'h100, 4'd1, 3'd2, 2'b10, -1);
      do_read(4'd9, 32'h100, 4'd1, 3'd2, 2'b01, 1'b0, -1);
      do_read(4'd11, 32'h100, 4'd0, 3'd3, 2'b01, 1'b0, -1);

      // wlast on beat 2 of 4: all beats written, SLVERR reported
      for (int i = 0; i < 4; i++) begin
         wbuf[i] = 32'hA0A0_0000 + i;
         sbuf[i] = 4'hF;
      end
      do_write(4'd10, 32'h400, 4'd3, 3'd2, 2'b01, 1);
      do_read(4'd10, 32'h400, 4'd3, 3'd2, 2'b01, 1'b0, -1);

      // address aliasing above the index bits
      wbuf[0] = 32'hCAFEF00D; sbuf[0] = 4'hF;
      do_write(4'd12, 32'h0000_4040, 4'd0, 3'd2, 2'b01, -1);
      do_read(4'd12, 32'h40, 4'd0, 3'd2, 2'b01, 1'b0, -1);

      // halfword INCR steps two bytes per beat
      for (int i = 0; i < 4; i++) begin
         wbuf[i] = 32'h5000_0000 + (i * 32'h0001_0001);
         sbuf[i] = (i % 2 == 0) ? 4'h3 : 4'hC;
      end
      do_write(4'd13, 32'h500, 4'd3, 3'd1, 2'b01, -1);
      do_read(4'd13, 32'h500, 4'd1, 3'd2, 2'b01, 1'b0, -1);

      // reset during beat 5 of a 16-beat read
      do_read(4'd14, 32'h100, 4'd15, 3'd2, 2'b01, 1'b0, 4);
      chk("pre_reset_rvalid", axi.rvalid, 1);
      axi.rready = 1'b0;
      aresetn = 1'b0;
      #1;
      chk("midrst_rvalid", axi.rvalid, 0);
      chk("midrst_rlast", axi.rlast, 0);
      chk("midrst_rdata", axi.rdata, 0);
      chk("midrst_arready", axi.arready, 0);
      chk("midrst_rid", axi.rid, 0);
      rq.delete();
      repeat (3) @(posedge aclk);
      @(negedge aclk);
      aresetn = 1'b1;
      #1;
      chk("rel_arready_before_edge", axi.arready, 0);
      tick();
      chk("rel_arready_first_edge", axi.arready, 1);
      do_read(4'd15, 32'h100, 4'd1, 3'd2, 2'b01, 1'b0, -1);
      do_read(4'd15, 32'h40, 4'd0, 3'd2, 2'b01, 1'b0, -1);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL global_timeout: observed=time limit expected=bench completion");
      $fatal(1, "global timeout");
   end
endmodule
